priority_decoder: RTL

Registered binary-to-one-hot decoder: the inverse of the team's N-input priority encoder. Accepts an M-bit index over a valid/ready handshake and delivers the corresponding N-bit one-hot vector (or the all-zero vector) over a second valid/ready handshake. A two-entry skid buffer sustains one transfer per cycle under backpressure with a fully registered `in_ready`. The block sits between control logic that produces encoded indices and datapath logic that needs per-line select or enable strobes.

---
 rtl/priority_decoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/priority_decoder.sv
// Registered binary-to-one-hot decoder behind a two-entry skid buffer.
// The decode is done at acceptance; D/out_err/out_valid always show MAIN.
module priority_decoder #(
  parameter int N  = 8,
  parameter int M  = $clog2(N),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_idx,
  input  logic          in_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  D,
  output logic          out_err,
  output logic [CW-1:0] dec_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  localparam logic [M:0] NL = (M+1)'(N);

  state_t       state, state_nxt;
  logic [N-1:0] main_d, main_d_nxt;
  logic [N-1:0] skid_d, skid_d_nxt;
  logic         main_err, main_err_nxt;
  logic         skid_err, skid_err_nxt;
  logic [N-1:0] beat_d;
  logic         beat_err, beat_hot;
  logic         acc, drn;

  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign D         = main_d;
  assign out_err   = main_err;

  always_comb begin
    beat_d   = '0;
    beat_err = 1'b0;
    beat_hot = 1'b0;
    if (!in_zero) begin
      if ({1'b0, in_idx} < NL) begin
        beat_d   = N'(1) << in_idx;
        beat_hot = 1'b1;
      end else begin
        beat_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    main_d_nxt   = main_d;
    main_err_nxt = main_err;
    skid_d_nxt   = skid_d;
    skid_err_nxt = skid_err;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt    = ONE;
          main_d_nxt   = beat_d;
          main_err_nxt = beat_err;
        end
      end
      ONE: begin
        if (acc && !drn) begin
          state_nxt    = FULL;
          skid_d_nxt   = beat_d;
          skid_err_nxt = beat_err;
        end else if (acc && drn) begin
          main_d_nxt   = beat_d;
          main_err_nxt = beat_err;
        end else if (drn) begin
          // An empty buffer presents the all-zero vector.
          state_nxt    = EMPTY;
          main_d_nxt   = '0;
          main_err_nxt = 1'b0;
        end
      end
      FULL: begin
        if (drn) begin
          state_nxt    = ONE;
          main_d_nxt   = skid_d;
          main_err_nxt = skid_err;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_d   <= '0;
      main_err <= 1'b0;
      skid_d   <= '0;
      skid_err <= 1'b0;
      dec_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      main_d   <= main_d_nxt;
      main_err <= main_err_nxt;
      skid_d   <= skid_d_nxt;
      skid_err <= skid_err_nxt;
      if (acc && beat_hot)
        dec_cnt <= dec_cnt + CW'(1);
    end
  end

endmodule
